// File: rtl/shift_register_array.sv
// shift_register_array
// N_CH independent DEPTH-bit shift registers that present stimulus to the
// compressor-under-test as one flattened vector, plus a registered golden
// popcount of that vector for checking the compressor result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of array and fill counter
//   load_en    parallel load of the whole array from load_data
//   load_data  parallel load value, same layout as src_flat
//   shift_en   shift every channel by one bit
//   dir        0: shift toward MSB (new bit at bit 0)
//              1: shift toward LSB (new bit at bit DEPTH-1)
//   src_in     serial input bit per channel (bit c feeds channel c)
//   src_flat   array contents, channel c at [c*DEPTH +: DEPTH]
//   fill_cnt   bits shifted in since clear/reset, saturating at DEPTH
//   full       fill_cnt == DEPTH
//   pop_sum    count of ones in src_flat, one cycle behind the array
//   pop_valid  full, one cycle behind; qualifies pop_sum
module shift_register_array #(
    parameter int N_CH  = 10,
    parameter int DEPTH = 10,
    parameter int SUM_W = $clog2(N_CH*DEPTH+1),
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load_en,
    input  logic [N_CH*DEPTH-1:0]   load_data,
    input  logic                    shift_en,
    input  logic                    dir,
    input  logic [N_CH-1:0]         src_in,
    output logic [N_CH*DEPTH-1:0]   src_flat,
    output logic [CNT_W-1:0]        fill_cnt,
    output logic                    full,
    output logic [SUM_W-1:0]        pop_sum,
    output logic                    pop_valid
);

    localparam int W = N_CH * DEPTH;

    // The shift slices below need at least two bits per channel.
    if (DEPTH < 2 || N_CH < 1) begin : g_bad_param
        $error("shift_register_array: DEPTH must be >= 2 and N_CH >= 1");
    end

    // Count of ones across the whole array; unsigned, cannot overflow SUM_W.
    function automatic logic [SUM_W-1:0] popcount(input logic [W-1:0] v);
        logic [SUM_W-1:0] sum;
        sum = {SUM_W{1'b0}};
        for (int i = 0; i < W; i++) begin
            sum = sum + SUM_W'(v[i]);
        end
        return sum;
    endfunction

    logic [W-1:0]     array_r;
    logic [W-1:0]     array_nxt_s;
    logic [W-1:0]     shifted_s;
    logic [CNT_W-1:0] fill_cnt_r;
    logic [CNT_W-1:0] fill_nxt_s;
    logic             full_s;
    logic [SUM_W-1:0] pop_sum_r;
    logic             pop_valid_r;

    assign full_s = (fill_cnt_r == CNT_W'(DEPTH));

    // Per-channel one-bit shift in the selected direction.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign shifted_s[c*DEPTH +: DEPTH] = dir
            ? {src_in[c], array_r[c*DEPTH+1 +: DEPTH-1]}
            : {array_r[c*DEPTH +: DEPTH-1], src_in[c]};
    end

    // Next-state selection: clr beats load_en beats shift_en beats hold.
    always_comb begin
        array_nxt_s = array_r;
        fill_nxt_s  = fill_cnt_r;
        if (clr) begin
            array_nxt_s = {W{1'b0}};
            fill_nxt_s  = {CNT_W{1'b0}};
        end else if (load_en) begin
            array_nxt_s = load_data;
            fill_nxt_s  = CNT_W'(DEPTH);
        end else if (shift_en) begin
            array_nxt_s = shifted_s;
            if (full_s) begin
                fill_nxt_s = fill_cnt_r;
            end else begin
                fill_nxt_s = fill_cnt_r + CNT_W'(1);
            end
        end else begin
            array_nxt_s = array_r;
            fill_nxt_s  = fill_cnt_r;
        end
    end

    // Array and fill counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            array_r    <= {W{1'b0}};
            fill_cnt_r <= {CNT_W{1'b0}};
        end else begin
            array_r    <= array_nxt_s;
            fill_cnt_r <= fill_nxt_s;
        end
    end

    // Golden popcount stage: samples the array every edge, ungated, so it
    // trails the array (and a clear) by exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_sum_r   <= {SUM_W{1'b0}};
            pop_valid_r <= 1'b0;
        end else begin
            pop_sum_r   <= popcount(array_r);
            pop_valid_r <= full_s;
        end
    end

    assign src_flat  = array_r;
    assign fill_cnt  = fill_cnt_r;
    assign full      = full_s;
    assign pop_sum   = pop_sum_r;
    assign pop_valid = pop_valid_r;

endmodule

// File: tb/tb_shift_register_array.sv
module tb_shift_register_array;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    // default instance (10 x 10)
    logic         clr = 1'b0, load_en = 1'b0, shift_en = 1'b0, dir = 1'b0;
    logic [99:0]  load_data = '0;
    logic [9:0]   src_in = '0;
    logic [99:0]  src_flat;
    logic [3:0]   fill_cnt;
    logic         full;
    logic [6:0]   pop_sum;
    logic         pop_valid;
    // small instance (3 x 4)
    logic         clr_b = 1'b0, load_en_b = 1'b0, shift_en_b = 1'b0, dir_b = 1'b0;
    logic [11:0]  load_data_b = '0;
    logic [2:0]   src_in_b = '0;
    logic [11:0]  src_flat_b;
    logic [2:0]   fill_cnt_b;
    logic         full_b;
    logic [3:0]   pop_sum_b;
    logic         pop_valid_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_register_array dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load_en(load_en),
        .load_data(load_data), .shift_en(shift_en), .dir(dir),
        .src_in(src_in), .src_flat(src_flat), .fill_cnt(fill_cnt),
        .full(full), .pop_sum(pop_sum), .pop_valid(pop_valid)
    );

    shift_register_array #(.N_CH(3), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .load_en(load_en_b),
        .load_data(load_data_b), .shift_en(shift_en_b), .dir(dir_b),
        .src_in(src_in_b), .src_flat(src_flat_b), .fill_cnt(fill_cnt_b),
        .full(full_b), .pop_sum(pop_sum_b), .pop_valid(pop_valid_b)
    );

    // advance one rising edge, then settle before sampling / driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; load_en = 1'b0; shift_en = 1'b0; dir = 1'b0;
        load_data = '0; src_in = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        n_checks++; if (src_flat !== 100'd0) begin n_fail++; $display("FAIL reset_flat: got %h expected 0", src_flat); end
        n_checks++; if (fill_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_cnt); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (pop_sum !== 7'd0) begin n_fail++; $display("FAIL reset_pop: got %0d expected 0", pop_sum); end
        n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pvalid: got %b expected 0", pop_valid); end
        // load all ones, let popcount catch up, then reset mid-cycle
        load_en = 1'b1; load_data = {100{1'b1}};
        step();
        idle_inputs();
        step();
        n_checks++; if (pop_sum !== 7'd100 || pop_valid !== 1'b1) begin n_fail++; $display("FAIL pre_async_pop: got %0d/%b expected 100/1", pop_sum, pop_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (src_flat !== 100'd0 || fill_cnt !== 4'd0 || full !== 1'b0) begin n_fail++; $display("FAIL async_reset_array: got %h/%0d/%b expected 0/0/0", src_flat, fill_cnt, full); end
        n_checks++; if (pop_sum !== 7'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_pop: got %0d/%b expected 0/0", pop_sum, pop_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_shift_fill();
        idle_inputs();
        src_in = 10'h3FF; shift_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_checks++; if (fill_cnt !== 4'(i)) begin n_fail++; $display("FAIL fill_step%0d: got %0d expected %0d", i, fill_cnt, i); end
            n_checks++; if (full !== (i == 10)) begin n_fail++; $display("FAIL full_step%0d: got %b expected %b", i, full, (i == 10)); end
        end
        n_checks++; if (src_flat !== {100{1'b1}}) begin n_fail++; $display("FAIL fill_flat: got %h expected all ones", src_flat); end
        n_checks++; if (pop_sum !== 7'd90) begin n_fail++; $display("FAIL fill_pop_lag: got %0d expected 90", pop_sum); end
        step(); // 11th shift
        n_checks++; if (fill_cnt !== 4'd10) begin n_fail++; $display("FAIL fill_saturate: got %0d expected 10", fill_cnt); end
        n_checks++; if (pop_sum !== 7'd100 || pop_valid !== 1'b1) begin n_fail++; $display("FAIL fill_pop: got %0d/%b expected 100/1", pop_sum, pop_valid); end
        idle_inputs();
    endtask

    task automatic test_direction();
        idle_inputs();
        clr = 1'b1;
        step();
        clr = 1'b0; shift_en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            src_in = (i == 0) ? 10'h001 : 10'h000;
            step();
        end
        n_checks++; if (src_flat !== 100'h200) begin n_fail++; $display("FAIL dir0_flat: got %h expected 200", src_flat); end
        dir = 1'b1; src_in = 10'h000;
        step();
        n_checks++; if (src_flat !== 100'h100) begin n_fail++; $display("FAIL dir1_flat: got %h expected 100", src_flat); end
        n_checks++; if (fill_cnt !== 4'd10) begin n_fail++; $display("FAIL dir_fill: got %0d expected 10", fill_cnt); end
        idle_inputs();
        step();
        n_checks++; if (src_flat !== 100'h100) begin n_fail++; $display("FAIL hold_flat: got %h expected 100", src_flat); end
        n_checks++; if (pop_sum !== 7'd1) begin n_fail++; $display("FAIL dir_pop: got %0d expected 1", pop_sum); end
    endtask

    task automatic test_load();
        logic [99:0] pat;
        pat = {25{4'b0101}};
        idle_inputs();
        clr = 1'b1;
        step();
        idle_inputs();
        step();
        n_checks++; if (full !== 1'b0 || pop_sum !== 7'd0) begin n_fail++; $display("FAIL preload_clear: got %b/%0d expected 0/0", full, pop_sum); end
        load_en = 1'b1; load_data = pat;
        step();
        idle_inputs();
        n_checks++; if (src_flat !== pat) begin n_fail++; $display("FAIL load_flat: got %h expected %h", src_flat, pat); end
        n_checks++; if (fill_cnt !== 4'd10 || full !== 1'b1) begin n_fail++; $display("FAIL load_fill: got %0d/%b expected 10/1", fill_cnt, full); end
        step();
        n_checks++; if (pop_sum !== 7'd50 || pop_valid !== 1'b1) begin n_fail++; $display("FAIL load_pop: got %0d/%b expected 50/1", pop_sum, pop_valid); end
    endtask

    task automatic test_clr_priority();
        clr = 1'b1; load_en = 1'b1; load_data = {100{1'b1}};
        shift_en = 1'b1; src_in = 10'h3FF;
        step();
        idle_inputs();
        n_checks++; if (src_flat !== 100'd0 || fill_cnt !== 4'd0 || full !== 1'b0) begin n_fail++; $display("FAIL clr_prio_array: got %h/%0d/%b expected 0/0/0", src_flat, fill_cnt, full); end
        n_checks++; if (pop_sum !== 7'd50 || pop_valid !== 1'b1) begin n_fail++; $display("FAIL clr_prio_pop_lag: got %0d/%b expected 50/1", pop_sum, pop_valid); end
        step();
        n_checks++; if (pop_sum !== 7'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL clr_prio_pop: got %0d/%b expected 0/0", pop_sum, pop_valid); end
    endtask

    task automatic test_small_params();
        shift_en_b = 1'b1; dir_b = 1'b0; src_in_b = 3'b111;
        repeat (4) step();
        n_checks++; if (fill_cnt_b !== 3'd4 || full_b !== 1'b1) begin n_fail++; $display("FAIL small_fill: got %0d/%b expected 4/1", fill_cnt_b, full_b); end
        src_in_b = 3'b000;
        step(); // 5th shift
        n_checks++; if (pop_sum_b !== 4'd12 || pop_valid_b !== 1'b1) begin n_fail++; $display("FAIL small_pop12: got %0d/%b expected 12/1", pop_sum_b, pop_valid_b); end
        n_checks++; if (src_flat_b !== 12'hEEE || fill_cnt_b !== 3'd4) begin n_fail++; $display("FAIL small_flat: got %h/%0d expected eee/4", src_flat_b, fill_cnt_b); end
        shift_en_b = 1'b0;
        step();
        n_checks++; if (pop_sum_b !== 4'd9) begin n_fail++; $display("FAIL small_pop9: got %0d expected 9", pop_sum_b); end
    endtask

    initial begin
        test_reset();
        test_shift_fill();
        test_direction();
        test_load();
        test_clr_priority();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
